// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time, feeds IF/ID.
// Define IF_FETCH_PERF_CNT_EN to build the fetch / discarded-ack performance counters.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic [31:0] fetch_count,
   output logic [15:0] redirect_drop_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc_reg;
   logic        drop_pending;
   logic        req_started;

   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc_reg;
   assign pc_plus4  = pc + PC_INC;

   // req_started marks that the memory may already be working on the current address,
   // so a redirect without an ack must swallow the one stale ack still to come.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         pc_reg       <= RESET_PC;
         instr        <= 32'h0;
         pc           <= RESET_PC;
         fetch_valid  <= 1'b0;
         drop_pending <= 1'b0;
         req_started  <= 1'b0;
      end else begin
         req_started <= (state == S_REQ);
         case (state)
            S_IDLE: begin
               state <= S_REQ;
            end
            S_REQ: begin
               if (branch_taken) begin
                  pc_reg <= branch_target;
                  if (imem_ack)
                     drop_pending <= 1'b0;
                  else if (req_started)
                     drop_pending <= 1'b1;
               end else if (imem_ack) begin
                  if (drop_pending) begin
                     drop_pending <= 1'b0;
                  end else begin
                     instr       <= imem_rdata;
                     pc          <= pc_reg;
                     fetch_valid <= 1'b1;
                     state       <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (branch_taken) begin
                  pc_reg      <= branch_target;
                  fetch_valid <= 1'b0;
                  instr       <= 32'h0;
                  state       <= S_REQ;
               end else if (pc_write) begin
                  pc_reg      <= pc_reg + PC_INC;
                  fetch_valid <= 1'b0;
                  instr       <= 32'h0;
                  state       <= S_REQ;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef IF_FETCH_PERF_CNT_EN
   logic consume_evt;
   logic discard_evt;

   assign consume_evt = (state == S_HOLD) && !branch_taken && pc_write;
   assign discard_evt = (state == S_REQ) && imem_ack && (branch_taken || drop_pending);

   // fetch_count wraps freely; the drop counter sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count         <= 32'h0;
         redirect_drop_count <= 16'h0;
      end else begin
         if (consume_evt)
            fetch_count <= fetch_count + 32'd1;
         if (discard_evt && (redirect_drop_count != 16'hFFFF))
            redirect_drop_count <= redirect_drop_count + 16'd1;
      end
   end
`else
   assign fetch_count         = 32'h0;
   assign redirect_drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, reset/wrap sequences,
// and randomized fetch traffic against a transaction-level PC model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write, branch_taken, imem_ack;
   logic [31:0] branch_target, imem_rdata;
   logic        imem_req, fetch_valid;
   logic [31:0] imem_addr, instr, pc, pc_plus4, fetch_count;
   logic [15:0] redirect_drop_count;

   logic        w_rst_n, w_pc_write, w_branch_taken, w_imem_ack;
   logic [31:0] w_branch_target, w_imem_rdata;
   logic        w_imem_req, w_fetch_valid;
   logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4, w_fetch_count;
   logic [15:0] w_redirect_drop_count;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   if_fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .pc(pc),
      .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .fetch_count(fetch_count),
      .redirect_drop_count(redirect_drop_count)
   );

   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(w_rst_n), .pc_write(w_pc_write), .branch_taken(w_branch_taken),
      .branch_target(w_branch_target), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata), .instr(w_instr), .pc(w_pc),
      .pc_plus4(w_pc_plus4), .fetch_valid(w_fetch_valid), .fetch_count(w_fetch_count),
      .redirect_drop_count(w_redirect_drop_count)
   );

   typedef struct {
      logic        pw;
      logic        br;
      logic [31:0] tgt;
      logic        ack;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[26];

   function automatic vec_t mk(input logic pw, input logic br, input logic [31:0] tgt,
                               input logic ack, input logic [31:0] rdata,
                               input logic exp_req, input logic [31:0] exp_addr,
                               input logic exp_valid, input logic [31:0] exp_pc,
                               input logic [31:0] exp_instr);
      vec_t v;
      v.pw = pw; v.br = br; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
      v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_valid = exp_valid;
      v.exp_pc = exp_pc; v.exp_instr = exp_instr;
      return v;
   endfunction

   // Instruction word the random-mode memory returns for a given address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a ^ 32'h5A5A_0000) + 32'h13;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic pw, input logic br, input logic [31:0] tgt,
                                input logic ack, input logic [31:0] rdata);
      pc_write      = pw;
      branch_taken  = br;
      branch_target = tgt;
      imem_ack      = ack;
      imem_rdata    = rdata;
   endtask

   // Leaves the DUT in S_IDLE at a falling edge with rst_n just released.
   task automatic doReset(input string tag);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput({tag, ".rst_req"},   32'(imem_req), 32'h0);
      checkOutput({tag, ".rst_valid"}, 32'(fetch_valid), 32'h0);
      checkOutput({tag, ".rst_pc"},    pc, 32'h0);
      checkOutput({tag, ".rst_instr"}, instr, 32'h0);
      checkOutput({tag, ".rst_fcnt"},  fetch_count, 32'h0);
      checkOutput({tag, ".rst_dcnt"},  32'(redirect_drop_count), 32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] model_pc, tgt, maddr;
      int          cons, idle_cycles, wait_cnt;
      logic        busy, br, pw;
      logic [31:0] exp_fc;
      logic [15:0] exp_dc;

      w_rst_n = 1'b0; w_pc_write = 1'b1; w_branch_taken = 1'b0;
      w_branch_target = 32'h0; w_imem_ack = 1'b1; w_imem_rdata = 32'h0000_0013;

      // Sequential fetch, stall at 0x8, redirect during a slow fetch, branch+stall in hold.
      vecs[0]  = mk(1,0,32'h0,  0,32'h0,        0,32'h0,  0,32'h0,  32'h0);
      vecs[1]  = mk(1,0,32'h0,  1,32'h0000_0013,1,32'h0,  0,32'h0,  32'h0);
      vecs[2]  = mk(1,0,32'h0,  0,32'h0,        0,32'h0,  1,32'h0,  32'h0000_0013);
      vecs[3]  = mk(1,0,32'h0,  1,32'h0040_0093,1,32'h4,  0,32'h0,  32'h0);
      vecs[4]  = mk(1,0,32'h0,  0,32'h0,        0,32'h4,  1,32'h4,  32'h0040_0093);
      vecs[5]  = mk(1,0,32'h0,  1,32'h0080_0113,1,32'h8,  0,32'h4,  32'h0);
      for (int i = 6; i <= 10; i++)
         vecs[i] = mk(0,0,32'h0,0,32'h0,        0,32'h8,  1,32'h8,  32'h0080_0113);
      vecs[11] = mk(1,0,32'h0,  0,32'h0,        0,32'h8,  1,32'h8,  32'h0080_0113);
      vecs[12] = mk(1,0,32'h0,  1,32'h00C0_0193,1,32'hC,  0,32'h8,  32'h0);
      vecs[13] = mk(1,0,32'h0,  0,32'h0,        0,32'hC,  1,32'hC,  32'h00C0_0193);
      vecs[14] = mk(1,0,32'h0,  0,32'h0,        1,32'h10, 0,32'hC,  32'h0);
      vecs[15] = mk(1,1,32'h100,0,32'h0,        1,32'h10, 0,32'hC,  32'h0);
      vecs[16] = mk(1,0,32'h0,  0,32'h0,        1,32'h100,0,32'hC,  32'h0);
      vecs[17] = mk(1,0,32'h0,  1,32'hDEAD_BEEF,1,32'h100,0,32'hC,  32'h0);
      vecs[18] = mk(1,0,32'h0,  0,32'h0,        1,32'h100,0,32'hC,  32'h0);
      vecs[19] = mk(1,0,32'h0,  0,32'h0,        1,32'h100,0,32'hC,  32'h0);
      vecs[20] = mk(1,0,32'h0,  1,32'h1000_0213,1,32'h100,0,32'hC,  32'h0);
      vecs[21] = mk(0,1,32'h20, 0,32'h0,        0,32'h100,1,32'h100,32'h1000_0213);
      vecs[22] = mk(1,0,32'h0,  1,32'h0200_0293,1,32'h20, 0,32'h100,32'h0);
      vecs[23] = mk(1,1,32'h40, 0,32'h0,        0,32'h20, 1,32'h20, 32'h0200_0293);
      vecs[24] = mk(1,0,32'h0,  1,32'h0400_0313,1,32'h40, 0,32'h20, 32'h0);
      vecs[25] = mk(0,0,32'h0,  0,32'h0,        0,32'h40, 1,32'h40, 32'h0400_0313);

      doReset("tbl");
      for (int i = 0; i < 26; i++) begin
         checkOutput($sformatf("row%0d.req", i),   32'(imem_req),    32'(vecs[i].exp_req));
         checkOutput($sformatf("row%0d.addr", i),  imem_addr,        vecs[i].exp_addr);
         checkOutput($sformatf("row%0d.valid", i), 32'(fetch_valid), 32'(vecs[i].exp_valid));
         checkOutput($sformatf("row%0d.pc", i),    pc,               vecs[i].exp_pc);
         checkOutput($sformatf("row%0d.instr", i), instr,            vecs[i].exp_instr);
         checkOutput($sformatf("row%0d.pc4", i),   pc_plus4,         vecs[i].exp_pc + 32'd4);
         applyStimulus(vecs[i].pw, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
         @(negedge clk);
      end
`ifdef IF_FETCH_PERF_CNT_EN
      exp_fc = 32'd4;
      exp_dc = 16'd1;
`else
      exp_fc = 32'd0;
      exp_dc = 16'd0;
`endif
      checkOutput("tbl.fetch_count", fetch_count, exp_fc);
      checkOutput("tbl.drop_count", 32'(redirect_drop_count), 32'(exp_dc));

      // Reset asserted mid-request; a late ack in S_IDLE must be ignored.
      doReset("arst");
      @(negedge clk);
      checkOutput("arst.req_before", 32'(imem_req), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("arst.req_async_drop", 32'(imem_req), 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      checkOutput("arst.req_in_reset", 32'(imem_req), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("arst.req_after", 32'(imem_req), 32'h1);
      checkOutput("arst.addr_after", imem_addr, 32'h0);
      checkOutput("arst.valid_after", 32'(fetch_valid), 32'h0);
      @(negedge clk);
      checkOutput("arst.ack_ignored", 32'(fetch_valid), 32'h0);
      checkOutput("arst.fetch_count", fetch_count, 32'h0);
      checkOutput("arst.drop_count", 32'(redirect_drop_count), 32'h0);

      // PC wrap-around from 0xFFFF_FFFC with an always-acking memory.
      w_rst_n = 1'b1;
      checkOutput("wrap.idle_addr", w_imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      checkOutput("wrap.req", 32'(w_imem_req), 32'h1);
      checkOutput("wrap.req_addr", w_imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      checkOutput("wrap.valid", 32'(w_fetch_valid), 32'h1);
      checkOutput("wrap.pc", w_pc, 32'hFFFF_FFFC);
      checkOutput("wrap.pc_plus4", w_pc_plus4, 32'h0);
      @(negedge clk);
      checkOutput("wrap.next_addr", w_imem_addr, 32'h0);

      // Random traffic: random memory latency, random stalls, random redirects in hold.
      doReset("rnd");
      model_pc = 32'h0;
      cons = 0; idle_cycles = 0; busy = 1'b0; wait_cnt = 0; maddr = 32'h0;
      for (int c = 0; c < 600; c++) begin
         if (fetch_valid) begin
            idle_cycles = 0;
            checkOutput("rnd.pc", pc, model_pc);
            checkOutput("rnd.instr", instr, memf(model_pc));
         end else begin
            idle_cycles++;
            checkOutput("rnd.nop", instr, 32'h0);
            if (idle_cycles > 12) begin
               mismatched++;
               $display("[TB] FAIL rnd.timeout: got %0d idle cycles expected at most 12", idle_cycles);
               break;
            end
         end
         if (imem_req)
            checkOutput("rnd.addr", imem_addr, model_pc);

         pw  = 1'($urandom_range(0, 1));
         br  = fetch_valid && ($urandom_range(0, 4) == 0);
         tgt = $urandom & 32'hFFFF_FFFC;
         if (fetch_valid) begin
            if (br)
               model_pc = tgt;
            else if (pw) begin
               model_pc = model_pc + 32'd4;
               cons++;
            end
         end

         imem_ack = 1'b0;
         if (imem_req) begin
            if (!busy) begin
               busy     = 1'b1;
               wait_cnt = $urandom_range(0, 3);
               maddr    = imem_addr;
            end
            if (wait_cnt == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = memf(maddr);
               busy       = 1'b0;
            end else begin
               wait_cnt--;
            end
         end
         pc_write      = pw;
         branch_taken  = br;
         branch_target = tgt;
         @(negedge clk);
      end
`ifdef IF_FETCH_PERF_CNT_EN
      exp_fc = 32'(cons);
`else
      exp_fc = 32'd0;
`endif
      checkOutput("rnd.fetch_count", fetch_count, exp_fc);
      checkOutput("rnd.drop_count", 32'(redirect_drop_count), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
